// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage
// Instruction fetch + IF/ID pipeline register for the WISC-F18 pipeline.
// Owns the PC and the IF/ID latch. Applies hazard-unit stalls and
// squashes the wrong-path fetch on a taken ID-stage branch. Freezes
// fetch once a HLT reaches IF/ID. Keeps saturating stall/flush counters.
// Every output is a register or a slice of one.
module fetch_ifid_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_write_en,
  input  logic             IFID_write_en,
  input  logic             branch_taken,
  input  logic [15:0]      branch_target,
  input  logic [15:0]      imem_data,
  output logic [15:0]      pc_out,
  output logic [15:0]      IFID_instr,
  output logic [15:0]      IFID_pc_plus2,
  output logic             IFID_valid,
  output logic [3:0]       IFID_opcode,
  output logic [3:0]       IFID_RegisterRs,
  output logic [3:0]       IFID_RegisterRt,
  output logic [2:0]       IFID_condition,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_pc;
  logic [15:0]      r_instr;
  logic [15:0]      r_pc_plus2;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [15:0]      w_pc_nxt;
  logic [15:0]      w_instr_nxt;
  logic [15:0]      w_pc_plus2_nxt;
  logic             w_valid_nxt;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_fetch_hlt;
  logic [15:0]      w_pc_inc;

  // A HLT only counts when it is not on a path being redirected away.
  assign w_fetch_hlt = (imem_data[15:12] == 4'b1111) & ~branch_taken;
  // Sequential fetch address; wraps naturally at 16 bits.
  assign w_pc_inc    = r_pc + 16'd2;

  // Next-state logic: PC priority, IF/ID load/hold/bubble, halt entry.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_pc_plus2_nxt = r_pc_plus2;
    w_valid_nxt    = r_valid;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_stall_inc = ~PC_write_en;
        // PC: stall beats redirect beats HLT hold beats sequential.
        if (!PC_write_en)      w_pc_nxt = r_pc;
        else if (branch_taken) w_pc_nxt = branch_target;
        else if (w_fetch_hlt)  w_pc_nxt = r_pc;
        else                   w_pc_nxt = w_pc_inc;
        // IF/ID: a held latch keeps its contents even under a branch.
        if (IFID_write_en) begin
          if (branch_taken && PC_write_en) begin
            w_instr_nxt    = 16'h0000;
            w_pc_plus2_nxt = 16'h0000;
            w_valid_nxt    = 1'b0;
            w_flush_inc    = 1'b1;
          end else begin
            w_instr_nxt    = imem_data;
            w_pc_plus2_nxt = w_pc_inc;
            w_valid_nxt    = 1'b1;
            // HLT is now in IF/ID; freeze fetch from here on.
            if (w_fetch_hlt) w_state_nxt = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        // PC frozen; each permitted IF/ID write drains in a bubble.
        if (IFID_write_en) begin
          w_instr_nxt    = 16'h0000;
          w_pc_plus2_nxt = 16'h0000;
          w_valid_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_instr    <= 16'h0000;
      r_pc_plus2 <= 16'h0000;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_pc_plus2 <= w_pc_plus2_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // Saturating event counters; they stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign pc_out          = r_pc;
  assign IFID_instr      = r_instr;
  assign IFID_pc_plus2   = r_pc_plus2;
  assign IFID_valid      = r_valid;
  assign IFID_opcode     = r_instr[15:12];
  assign IFID_RegisterRs = r_instr[7:4];
  assign IFID_RegisterRt = r_instr[3:0];
  assign IFID_condition  = r_instr[11:9];
  assign halted          = (r_state == S_HALTED);
  assign stall_cnt       = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed vector table, hand sequences for
// halt / branch-vs-halt / wrap / saturation, then random traffic against
// a behavioural model of the fetch rules.
module tb_fetch_ifid_stage;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pwe, iwe, bt;
  logic [15:0]   tgt;
  logic [15:0]   imem;
  logic [15:0]   pc_out, IFID_instr, IFID_pc_plus2;
  logic          IFID_valid, halted;
  logic [3:0]    IFID_opcode, IFID_RegisterRs, IFID_RegisterRt;
  logic [2:0]    IFID_condition;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic [15:0] mem [0:32767];
  assign imem = mem[pc_out[15:1]];

  always #5 clk = ~clk;

  fetch_ifid_stage #(.RESET_PC(16'h0000), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .PC_write_en(pwe), .IFID_write_en(iwe),
    .branch_taken(bt), .branch_target(tgt), .imem_data(imem),
    .pc_out(pc_out), .IFID_instr(IFID_instr), .IFID_pc_plus2(IFID_pc_plus2),
    .IFID_valid(IFID_valid), .IFID_opcode(IFID_opcode),
    .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
    .IFID_condition(IFID_condition), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model state
  logic [15:0]   m_pc, m_instr, m_pp2;
  logic          m_valid, m_halt;
  logic [CW-1:0] m_stall, m_flush;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic m_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0; m_stall = '0; m_flush = '0;
  endtask

  // One clock edge of the fetch rules, applied to the model.
  task automatic m_step(input logic p, input logic i, input logic b, input logic [15:0] t);
    logic [15:0] w;
    logic        h;
    w = mem[m_pc[15:1]];
    if (m_halt) begin
      if (i) begin m_instr = 0; m_pp2 = 0; m_valid = 0; end
    end else begin
      h = (w[15:12] == 4'hF) && !b;
      if (i) begin
        if (b && p) begin
          m_instr = 0; m_pp2 = 0; m_valid = 0;
          if (m_flush != {CW{1'b1}}) m_flush = m_flush + 1'b1;
        end else begin
          m_instr = w; m_pp2 = m_pc + 16'd2; m_valid = 1;
          if (h) m_halt = 1;
        end
      end
      if (!p) begin
        if (m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
      end else if (b) m_pc = t;
      else if (!h) m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic cmp_all(input string nm);
    chk(nm, {4'h0, pc_out, IFID_instr, IFID_pc_plus2, IFID_valid, halted, stall_cnt, flush_cnt},
            {4'h0, m_pc, m_instr, m_pp2, m_valid, m_halt, m_stall, m_flush});
    chk({nm, "_fields"}, {49'h0, IFID_opcode, IFID_condition, IFID_RegisterRs, IFID_RegisterRt},
            {49'h0, m_instr[15:12], m_instr[11:9], m_instr[7:4], m_instr[3:0]});
  endtask

  task automatic cyc(input logic p, input logic i, input logic b, input logic [15:0] t, input string nm);
    pwe = p; iwe = i; bt = b; tgt = t;
    m_step(p, i, b, t);
    @(posedge clk); #1;
    cmp_all(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pwe = 0; iwe = 0; bt = 0; tgt = 0;
    #2;
    m_reset();
    cmp_all("reset_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] seq_word(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  task automatic fill_seq();
    for (int k = 0; k < 32768; k++) mem[k] = seq_word(16'(k * 2));
  endtask

  task automatic fill_rand();
    logic [15:0] w;
    for (int k = 0; k < 32768; k++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 19) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      mem[k] = w;
    end
  endtask

  typedef struct {
    logic p, i, b;
    logic [15:0] t, e_pc, e_pp2;
    logic e_v;
    int e_s, e_f;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [15:0] ei;
    pwe = 0; iwe = 0; bt = 0; tgt = 0;
    // p  i  b  tgt      pc       pp2      v  stall flush
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0002, 16'h0002, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0004, 16'h0004, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0006, 16'h0006, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0008, 16'h0008, 1, 0, 0});
    tbl.push_back('{1, 1, 1, 16'h0040, 16'h0040, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0042, 16'h0042, 1, 0, 1});
    tbl.push_back('{1, 1, 1, 16'h0010, 16'h0010, 16'h0000, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 1, 2});
    tbl.push_back('{0, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 2, 2});
    tbl.push_back('{0, 0, 1, 16'h0080, 16'h0010, 16'h0000, 0, 3, 2});
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0012, 16'h0012, 1, 3, 2});
    tbl.push_back('{0, 1, 0, 16'h0000, 16'h0012, 16'h0014, 1, 4, 2});
    tbl.push_back('{1, 0, 0, 16'h0000, 16'h0014, 16'h0014, 1, 4, 2});
    tbl.push_back('{1, 0, 1, 16'h0030, 16'h0030, 16'h0014, 1, 4, 2});
    tbl.push_back('{1, 1, 0, 16'h0000, 16'h0032, 16'h0032, 1, 4, 2});

    fill_seq();
    #1;
    do_reset();
    foreach (tbl[k]) begin
      pwe = tbl[k].p; iwe = tbl[k].i; bt = tbl[k].b; tgt = tbl[k].t;
      @(posedge clk); #1;
      ei = tbl[k].e_v ? seq_word(tbl[k].e_pp2 - 16'd2) : 16'h0000;
      chk($sformatf("vec%0d", k),
          {pc_out, IFID_pc_plus2, IFID_instr, 1'b0, IFID_valid, halted, 3'b0, stall_cnt, flush_cnt},
          {tbl[k].e_pc, tbl[k].e_pp2, ei, 1'b0, tbl[k].e_v, 1'b0, 3'b0, CW'(tbl[k].e_s), CW'(tbl[k].e_f)});
    end

    // HLT at 0x0020, reached by a branch
    fill_seq();
    mem[16'h0010] = 16'hF000;
    do_reset();
    cyc(1, 1, 1, 16'h0020, "hlt_br");
    cyc(1, 1, 0, 16'h0000, "hlt_enter");
    chk("hlt_state", {pc_out, IFID_instr, 15'h0, halted}, {16'h0020, 16'hF000, 15'h0, 1'b1});
    cyc(1, 0, 1, 16'h0050, "hlt_hold");
    chk("hlt_held", {pc_out, IFID_instr}, {16'h0020, 16'hF000});
    cyc(1, 1, 1, 16'h0050, "hlt_bubble");
    chk("hlt_br_ignored", {pc_out, 7'h0, IFID_valid, 3'h0, flush_cnt}, {16'h0020, 7'h0, 1'b0, 3'h0, CW'(1)});
    cyc(0, 1, 0, 16'h0000, "hlt_nostall");
    chk("hlt_stall_cnt", {3'h0, stall_cnt}, 8'h00);
    do_reset();
    cyc(1, 1, 0, 16'h0000, "post_hlt_reset");

    // HLT in IF with a taken branch in the same cycle
    mem[16'h0030] = 16'hF000;
    do_reset();
    cyc(1, 1, 1, 16'h0060, "hltbr_a");
    cyc(1, 1, 1, 16'h0070, "hltbr_b");
    chk("hltbr_nohalt", {pc_out, 6'h0, IFID_valid, halted}, {16'h0070, 6'h0, 1'b0, 1'b0});

    // PC wrap
    fill_seq();
    do_reset();
    cyc(1, 1, 1, 16'hFFFE, "wrap_br");
    cyc(1, 1, 0, 16'h0000, "wrap_step");
    chk("wrap", {pc_out, IFID_pc_plus2, 7'h0, IFID_valid}, {16'h0000, 16'h0000, 7'h0, 1'b1});

    // Counter saturation
    do_reset();
    for (int k = 0; k < 40; k++) cyc(0, 0, 0, 16'h0000, "sat_stall");
    chk("stall_sat", {3'h0, stall_cnt}, {3'h0, {CW{1'b1}}});
    for (int k = 0; k < 40; k++) cyc(1, 1, 1, 16'h0100, "sat_flush");
    chk("flush_sat", {3'h0, flush_cnt}, {3'h0, {CW{1'b1}}});

    // Random traffic against the model
    for (int ph = 0; ph < 6; ph++) begin
      fill_rand();
      do_reset();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 40) == 0) do_reset();
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
            16'($urandom) & 16'hFFFE, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
